// File: rtl/result_drain.sv
// result_drain: captures M*M result bursts into a ping-pong frame buffer and
// re-emits each whole frame on a valid/ready stream with last/row/col tags.
module result_drain #(
  parameter int M    = 3,
  parameter int DW   = 16,
  parameter int NBUF = 2
) (
  input  logic                                  CLK,
  input  logic                                  rst,
  input  logic                                  in_vld,
  input  logic [DW-1:0]                         in_data,
  input  logic                                  out_rdy,
  output logic                                  out_vld,
  output logic [DW-1:0]                         out_data,
  output logic                                  out_last,
  output logic [(M > 1 ? $clog2(M) : 1)-1:0]    out_row,
  output logic [(M > 1 ? $clog2(M) : 1)-1:0]    out_col,
  input  logic                                  clr_ovf,
  output logic                                  ovf,
  output logic                                  busy
);
  localparam int N  = M * M;
  localparam int IW = N > 1 ? $clog2(N) : 1;
  localparam int RW = M > 1 ? $clog2(M) : 1;
  localparam int PW = $clog2(NBUF);
  localparam int AW = $clog2(NBUF * N);

  logic [DW-1:0] mem_q [NBUF*N];
  logic [NBUF-1:0] full_q, full_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [IW-1:0] wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d;
  logic [RW-1:0] row_q, row_d, col_q, col_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic drop_q, drop_d, ovf_q, ovf_d, out_vld_q, out_vld_d;
  logic hs, free, start, accept, cur_drop, wr_en, wr_last, load, col_end;
  logic [AW-1:0] wr_addr, rd_addr;

  always_comb begin
    hs       = out_vld_q & out_rdy;
    free     = hs & (rd_idx_q == IW'(N - 1));
    start    = in_vld & (wr_idx_q == '0);
    // a slot freed by the reader in the frame-start cycle may be reused at once
    accept   = ~full_q[wr_ptr_q] | (free & (rd_ptr_q == wr_ptr_q));
    cur_drop = start ? ~accept : drop_q;
    wr_en    = in_vld & ~cur_drop;
    wr_last  = in_vld & (wr_idx_q == IW'(N - 1));
    wr_idx_d = wr_last ? '0 : wr_idx_q + IW'(in_vld);
    wr_ptr_d = wr_ptr_q + PW'(wr_last & ~cur_drop);
    drop_d   = wr_last ? 1'b0 : cur_drop;
    ovf_d    = (start & ~accept) | (ovf_q & ~clr_ovf);
    wr_addr  = AW'(wr_ptr_q) * AW'(N) + AW'(wr_idx_q);
    full_d   = full_q;
    if (free) full_d[rd_ptr_q] = 1'b0;
    if (wr_last & ~cur_drop) full_d[wr_ptr_q] = 1'b1;
    col_end    = col_q == RW'(M - 1);
    rd_ptr_d   = rd_ptr_q + PW'(free);
    rd_idx_d   = free ? '0 : rd_idx_q + IW'(hs);
    row_d      = free ? '0 : (hs & col_end) ? row_q + RW'(1) : row_q;
    col_d      = free ? '0 : hs ? (col_end ? '0 : col_q + RW'(1)) : col_q;
    load       = ~out_vld_q | hs;
    rd_addr    = AW'(rd_ptr_d) * AW'(N) + AW'(rd_idx_d);
    out_vld_d  = load ? full_q[rd_ptr_d] : out_vld_q;
    out_data_d = (load & full_q[rd_ptr_d]) ? mem_q[rd_addr] : out_data_q;
  end

  always_ff @(posedge CLK)
    if (wr_en) mem_q[wr_addr] <= in_data;

  always_ff @(posedge CLK or posedge rst)
    if (rst) begin
      full_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      wr_idx_q   <= '0;
      rd_idx_q   <= '0;
      row_q      <= '0;
      col_q      <= '0;
      drop_q     <= 1'b0;
      ovf_q      <= 1'b0;
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
    end else begin
      full_q     <= full_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_idx_q   <= wr_idx_d;
      rd_idx_q   <= rd_idx_d;
      row_q      <= row_d;
      col_q      <= col_d;
      drop_q     <= drop_d;
      ovf_q      <= ovf_d;
      out_vld_q  <= out_vld_d;
      out_data_q <= out_data_d;
    end

  assign out_vld  = out_vld_q;
  assign out_data = out_data_q;
  assign out_last = out_vld_q & (rd_idx_q == IW'(N - 1));
  assign out_row  = row_q;
  assign out_col  = col_q;
  assign ovf      = ovf_q;
  assign busy     = (|full_q) | (wr_idx_q != '0) | out_vld_q;
endmodule
